// File: rtl/riscv_memory_arbiter.sv
// riscv_memory_arbiter: shares one single-ported memory between the fetch port
// and the load/store port. Round-robin on ties, one access in flight at a time,
// with an optional bus-timeout watchdog.
module riscv_memory_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    instrReq,
   input  logic [ADDR_WIDTH-1:0]   instrAddress,
   output logic                    instrAck,
   output logic [DATA_WIDTH-1:0]   instrData,
   input  logic                    dataReq,
   input  logic                    dataWrite,
   input  logic [ADDR_WIDTH-1:0]   dataAddress,
   input  logic [DATA_WIDTH-1:0]   dataWriteData,
   input  logic [DATA_WIDTH/8-1:0] dataByteEnable,
   output logic                    dataAck,
   output logic [DATA_WIDTH-1:0]   dataReadData,
   output logic                    memRequest,
   output logic                    memWrite,
   output logic [ADDR_WIDTH-1:0]   memAddress,
   output logic [DATA_WIDTH-1:0]   memWriteData,
   output logic [DATA_WIDTH/8-1:0] memByteEnable,
   input  logic [DATA_WIDTH-1:0]   memReadData,
   input  logic                    memReady,
   output logic                    busError,
   output logic                    stall
);

   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY_INSTR, BUSY_DATA, DONE} state_t;
   typedef enum logic {GRANT_INSTR, GRANT_DATA} grant_t;

   state_t               state, next_state;
   grant_t               last_grant;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 busy;
   logic                 timeout_hit;

   logic                  mem_request_d, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_address_d;
   logic [DATA_WIDTH-1:0] mem_write_data_d;
   logic [BE_WIDTH-1:0]   mem_byte_enable_d;
   logic                  instr_ack_d, data_ack_d, bus_error_d;
   logic [DATA_WIDTH-1:0] instr_data_d, data_read_data_d;

   assign busy        = (state == BUSY_INSTR) || (state == BUSY_DATA);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
   assign stall       = (instrReq & ~instrAck) | (dataReq & ~dataAck);

   // State register, round-robin history and watchdog counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= GRANT_INSTR;
         cnt        <= '0;
      end else begin
         state <= next_state;
         if (state == IDLE && next_state == BUSY_DATA)
            last_grant <= GRANT_DATA;
         else if (state == IDLE && next_state == BUSY_INSTR)
            last_grant <= GRANT_INSTR;
         if (busy && next_state == state)
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
      end
   end

   // Next-state decision: grant in IDLE, finish on ready or timeout
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (instrReq && dataReq)
               next_state = (last_grant == GRANT_INSTR) ? BUSY_DATA : BUSY_INSTR;
            else if (dataReq)
               next_state = BUSY_DATA;
            else if (instrReq)
               next_state = BUSY_INSTR;
         end
         BUSY_INSTR, BUSY_DATA: begin
            if (memReady || timeout_hit)
               next_state = DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output values for the next cycle; mem* hold while busy, acks default low
   always_comb begin
      mem_request_d     = memRequest;
      mem_write_d       = memWrite;
      mem_address_d     = memAddress;
      mem_write_data_d  = memWriteData;
      mem_byte_enable_d = memByteEnable;
      instr_ack_d       = 1'b0;
      data_ack_d        = 1'b0;
      bus_error_d       = 1'b0;
      instr_data_d      = instrData;
      data_read_data_d  = dataReadData;
      case (state)
         IDLE: begin
            if (next_state == BUSY_DATA) begin
               mem_request_d     = 1'b1;
               mem_write_d       = dataWrite;
               mem_address_d     = dataAddress;
               mem_write_data_d  = dataWriteData;
               mem_byte_enable_d = dataByteEnable;
            end else if (next_state == BUSY_INSTR) begin
               mem_request_d     = 1'b1;
               mem_write_d       = 1'b0;
               mem_address_d     = instrAddress;
               mem_write_data_d  = '0;
               mem_byte_enable_d = '1;
            end
         end
         BUSY_INSTR: begin
            if (next_state == DONE) begin
               mem_request_d = 1'b0;
               mem_write_d   = 1'b0;
               instr_ack_d   = 1'b1;
               bus_error_d   = !memReady;
               instr_data_d  = memReady ? memReadData : '0;
            end
         end
         BUSY_DATA: begin
            if (next_state == DONE) begin
               mem_request_d    = 1'b0;
               mem_write_d      = 1'b0;
               data_ack_d       = 1'b1;
               bus_error_d      = !memReady;
               data_read_data_d = (memReady && !memWrite) ? memReadData : '0;
            end
         end
         default: ;
      endcase
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         memRequest    <= 1'b0;
         memWrite      <= 1'b0;
         memAddress    <= '0;
         memWriteData  <= '0;
         memByteEnable <= '0;
         instrAck      <= 1'b0;
         dataAck       <= 1'b0;
         busError      <= 1'b0;
         instrData     <= '0;
         dataReadData  <= '0;
      end else begin
         memRequest    <= mem_request_d;
         memWrite      <= mem_write_d;
         memAddress    <= mem_address_d;
         memWriteData  <= mem_write_data_d;
         memByteEnable <= mem_byte_enable_d;
         instrAck      <= instr_ack_d;
         dataAck       <= data_ack_d;
         busError      <= bus_error_d;
         instrData     <= instr_data_d;
         dataReadData  <= data_read_data_d;
      end
   end

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Testbench for riscv_memory_arbiter: per-cycle vector table plus directed
// sequences for wait states, reset mid-access and the bus timeout.
module tb_riscv_memory_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instrReq, dataReq, dataWrite, memReady;
   logic [31:0] instrAddress, dataAddress, dataWriteData, memReadData;
   logic [3:0]  dataByteEnable;

   logic        instrAck, dataAck, memRequest, memWrite, busError, stall;
   logic [31:0] instrData, dataReadData, memAddress, memWriteData;
   logic [3:0]  memByteEnable;

   logic        instrAck_t, dataAck_t, memRequest_t, memWrite_t, busError_t, stall_t;
   logic [31:0] instrData_t, dataReadData_t, memAddress_t, memWriteData_t;
   logic [3:0]  memByteEnable_t;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   riscv_memory_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .instrReq(instrReq), .instrAddress(instrAddress), .instrAck(instrAck), .instrData(instrData),
      .dataReq(dataReq), .dataWrite(dataWrite), .dataAddress(dataAddress),
      .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable),
      .dataAck(dataAck), .dataReadData(dataReadData),
      .memRequest(memRequest), .memWrite(memWrite), .memAddress(memAddress),
      .memWriteData(memWriteData), .memByteEnable(memByteEnable),
      .memReadData(memReadData), .memReady(memReady), .busError(busError), .stall(stall)
   );

   riscv_memory_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .rst_n(rst_n),
      .instrReq(instrReq), .instrAddress(instrAddress), .instrAck(instrAck_t), .instrData(instrData_t),
      .dataReq(dataReq), .dataWrite(dataWrite), .dataAddress(dataAddress),
      .dataWriteData(dataWriteData), .dataByteEnable(dataByteEnable),
      .dataAck(dataAck_t), .dataReadData(dataReadData_t),
      .memRequest(memRequest_t), .memWrite(memWrite_t), .memAddress(memAddress_t),
      .memWriteData(memWriteData_t), .memByteEnable(memByteEnable_t),
      .memReadData(memReadData), .memReady(memReady), .busError(busError_t), .stall(stall_t)
   );

   typedef struct {
      logic        rst_n;
      logic        ireq;
      logic [31:0] iaddr;
      logic        dreq;
      logic        dwr;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [3:0]  dbe;
      logic        mready;
      logic [31:0] mrdata;
      logic        e_mreq;
      logic        e_mwr;
      logic [31:0] e_maddr;
      logic [31:0] e_mwdata;
      logic [3:0]  e_mbe;
      logic        e_iack;
      logic [31:0] e_idata;
      logic        e_dack;
      logic [31:0] e_ddata;
      logic        e_stall;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic r, input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
      input logic [31:0] da, input logic [31:0] dd, input logic [3:0] be, input logic mr,
      input logic [31:0] md, input logic emq, input logic emw, input logic [31:0] ema,
      input logic [31:0] emd, input logic [3:0] emb, input logic eia, input logic [31:0] eid,
      input logic eda, input logic [31:0] edd, input logic est);
      vec_t v;
      v.rst_n = r;  v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwr = dw;
      v.daddr = da; v.dwdata = dd; v.dbe = be; v.mready = mr; v.mrdata = md;
      v.e_mreq = emq; v.e_mwr = emw; v.e_maddr = ema; v.e_mwdata = emd; v.e_mbe = emb;
      v.e_iack = eia; v.e_idata = eid; v.e_dack = eda; v.e_ddata = edd; v.e_stall = est;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n          = v.rst_n;
      instrReq       = v.ireq;
      instrAddress   = v.iaddr;
      dataReq        = v.dreq;
      dataWrite      = v.dwr;
      dataAddress    = v.daddr;
      dataWriteData  = v.dwdata;
      dataByteEnable = v.dbe;
      memReady       = v.mready;
      memReadData    = v.mrdata;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Fetch only
      vecs.push_back(mk(1,1,32'h100,0,0,0,0,4'h0,0,0,           0,0,0,0,4'h0,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h100,0,0,0,0,4'h0,1,32'h00500093, 1,0,32'h100,0,4'hF,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h100,0,0,0,0,4'h0,0,0,           0,0,0,0,4'h0,1,32'h00500093,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,4'h0,0,0,                 0,0,0,0,4'h0,0,0,0,0,0));
      // Store
      vecs.push_back(mk(1,0,0,1,1,32'h200,32'hDEADBEEF,4'h3,0,0,           0,0,0,0,4'h0,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,32'h200,32'hDEADBEEF,4'h3,0,0,           1,1,32'h200,32'hDEADBEEF,4'h3,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,1,1,32'h200,32'hDEADBEEF,4'h3,1,32'h12345678, 1,1,32'h200,32'hDEADBEEF,4'h3,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,4'h0,0,0,                            0,0,0,0,4'h0,0,0,1,0,0));
      // Reset, then tie: DATA, INSTR, DATA, INSTR
      vecs.push_back(mk(0,0,0,0,0,0,0,4'h0,0,0,                   0,0,0,0,4'h0,0,0,0,0,0));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,0,0,           0,0,0,0,4'h0,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,1,32'hAAAA0001, 1,0,32'h400,0,4'h3,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,0,0,           0,0,0,0,4'h0,0,0,1,32'hAAAA0001,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,0,0,           0,0,0,0,4'h0,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,1,32'hBBBB0002, 1,0,32'h300,0,4'hF,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,0,0,           0,0,0,0,4'h0,1,32'hBBBB0002,0,0,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,0,0,           0,0,0,0,4'h0,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,1,32'hCCCC0003, 1,0,32'h400,0,4'h3,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,0,0,           0,0,0,0,4'h0,0,0,1,32'hCCCC0003,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,0,0,           0,0,0,0,4'h0,0,0,0,0,1));
      vecs.push_back(mk(1,1,32'h300,1,0,32'h400,0,4'h3,1,32'hDDDD0004, 1,0,32'h300,0,4'hF,0,0,0,0,1));
      vecs.push_back(mk(1,0,0,0,0,0,0,4'h0,0,0,                       0,0,0,0,4'h0,1,32'hDDDD0004,0,0,0));
      // memReady while idle is ignored
      vecs.push_back(mk(1,0,0,0,0,0,0,4'h0,1,32'hFFFFFFFF, 0,0,0,0,4'h0,0,0,0,0,0));
      vecs.push_back(mk(1,0,0,0,0,0,0,4'h0,0,0,            0,0,0,0,4'h0,0,0,0,0,0));

      // Reset state
      drive(mk(0,0,0,0,0,0,0,4'h0,0,0, 0,0,0,0,4'h0,0,0,0,0,0));
      next_cycle();
      next_cycle();
      @(negedge clk);
      chk("rst memRequest", {31'd0, memRequest}, 0);
      chk("rst memWrite", {31'd0, memWrite}, 0);
      chk("rst memAddress", memAddress, 0);
      chk("rst memByteEnable", {28'd0, memByteEnable}, 0);
      chk("rst instrAck", {31'd0, instrAck}, 0);
      chk("rst dataAck", {31'd0, dataAck}, 0);
      chk("rst instrData", instrData, 0);
      chk("rst dataReadData", dataReadData, 0);
      chk("rst busError", {31'd0, busError}, 0);
      chk("rst stall", {31'd0, stall}, 0);
      next_cycle();

      // Table-driven per-cycle vectors
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         chk($sformatf("v%0d memRequest", i), {31'd0, memRequest}, {31'd0, vecs[i].e_mreq});
         chk($sformatf("v%0d memWrite", i), {31'd0, memWrite}, {31'd0, vecs[i].e_mwr});
         chk($sformatf("v%0d instrAck", i), {31'd0, instrAck}, {31'd0, vecs[i].e_iack});
         chk($sformatf("v%0d dataAck", i), {31'd0, dataAck}, {31'd0, vecs[i].e_dack});
         chk($sformatf("v%0d stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
         chk($sformatf("v%0d busError", i), {31'd0, busError}, 0);
         if (vecs[i].e_mreq) begin
            chk($sformatf("v%0d memAddress", i), memAddress, vecs[i].e_maddr);
            chk($sformatf("v%0d memByteEnable", i), {28'd0, memByteEnable}, {28'd0, vecs[i].e_mbe});
         end
         if (vecs[i].e_mwr)
            chk($sformatf("v%0d memWriteData", i), memWriteData, vecs[i].e_mwdata);
         if (vecs[i].e_iack)
            chk($sformatf("v%0d instrData", i), instrData, vecs[i].e_idata);
         if (vecs[i].e_dack)
            chk($sformatf("v%0d dataReadData", i), dataReadData, vecs[i].e_ddata);
         next_cycle();
      end

      // Wait states: memReady held off for 5 busy cycles
      drive(mk(1,0,0,1,0,32'h500,0,4'hF,0,0, 0,0,0,0,4'h0,0,0,0,0,0));
      @(negedge clk);
      chk("ws idle memRequest", {31'd0, memRequest}, 0);
      chk("ws idle stall", {31'd0, stall}, 1);
      next_cycle();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("ws%0d memRequest", k), {31'd0, memRequest}, 1);
         chk($sformatf("ws%0d memAddress", k), memAddress, 32'h500);
         chk($sformatf("ws%0d memWrite", k), {31'd0, memWrite}, 0);
         chk($sformatf("ws%0d memByteEnable", k), {28'd0, memByteEnable}, 32'hF);
         chk($sformatf("ws%0d stall", k), {31'd0, stall}, 1);
         chk($sformatf("ws%0d dataAck", k), {31'd0, dataAck}, 0);
         next_cycle();
      end
      memReady    = 1'b1;
      memReadData = 32'h5A5A5A5A;
      @(negedge clk);
      chk("ws ready memRequest", {31'd0, memRequest}, 1);
      chk("ws ready dataAck", {31'd0, dataAck}, 0);
      next_cycle();
      memReady = 1'b0;
      dataReq  = 1'b0;
      @(negedge clk);
      chk("ws ack dataAck", {31'd0, dataAck}, 1);
      chk("ws ack dataReadData", dataReadData, 32'h5A5A5A5A);
      chk("ws ack memRequest", {31'd0, memRequest}, 0);
      next_cycle();

      // Reset in the middle of a data access
      drive(mk(1,0,0,1,1,32'h700,32'h11112222,4'hF,0,0, 0,0,0,0,4'h0,0,0,0,0,0));
      @(negedge clk);
      chk("rm idle memRequest", {31'd0, memRequest}, 0);
      next_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      chk("rm busy memRequest", {31'd0, memRequest}, 1);
      next_cycle();
      rst_n   = 1'b1;
      dataReq = 1'b0;
      @(negedge clk);
      chk("rm after memRequest", {31'd0, memRequest}, 0);
      chk("rm after dataAck", {31'd0, dataAck}, 0);
      next_cycle();
      @(negedge clk);
      chk("rm later dataAck", {31'd0, dataAck}, 0);
      drive(mk(1,1,32'h800,1,0,32'h900,0,4'h3,0,0, 0,0,0,0,4'h0,0,0,0,0,0));
      next_cycle();
      @(negedge clk);
      chk("rm tie memRequest", {31'd0, memRequest}, 1);
      chk("rm tie memAddress", memAddress, 32'h900);
      chk("rm tie memByteEnable", {28'd0, memByteEnable}, 32'h3);
      memReady    = 1'b1;
      memReadData = 32'h0BADF00D;
      next_cycle();
      memReady = 1'b0;
      instrReq = 1'b0;
      dataReq  = 1'b0;
      @(negedge clk);
      chk("rm tie dataAck", {31'd0, dataAck}, 1);
      chk("rm tie dataReadData", dataReadData, 32'h0BADF00D);
      next_cycle();

      // Timeout on the TIMEOUT_CYCLES=4 instance
      drive(mk(1,0,0,1,0,32'h600,0,4'hF,0,0, 0,0,0,0,4'h0,0,0,0,0,0));
      @(negedge clk);
      chk("to idle memRequest", {31'd0, memRequest_t}, 0);
      next_cycle();
      for (int k = 1; k <= 5; k++) begin
         if (k == 5) dataReq = 1'b0;
         @(negedge clk);
         if (k < 5) begin
            chk($sformatf("to%0d memRequest", k), {31'd0, memRequest_t}, 1);
            chk($sformatf("to%0d dataAck", k), {31'd0, dataAck_t}, 0);
            chk($sformatf("to%0d busError", k), {31'd0, busError_t}, 0);
         end else begin
            chk("to dataAck", {31'd0, dataAck_t}, 1);
            chk("to busError", {31'd0, busError_t}, 1);
            chk("to dataReadData", dataReadData_t, 0);
            chk("to memRequest", {31'd0, memRequest_t}, 0);
         end
         next_cycle();
      end
      instrReq     = 1'b1;
      instrAddress = 32'h640;
      @(negedge clk);
      chk("to post dataAck", {31'd0, dataAck_t}, 0);
      chk("to post busError", {31'd0, busError_t}, 0);
      chk("to post memRequest", {31'd0, memRequest_t}, 0);
      next_cycle();
      @(negedge clk);
      chk("to regrant memRequest", {31'd0, memRequest_t}, 1);
      chk("to regrant memAddress", memAddress_t, 32'h640);
      chk("to regrant memByteEnable", {28'd0, memByteEnable_t}, 32'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/riscv_memory_arbiter.md
Name: riscv_memory_arbiter

Overview:
- Shares one single-ported memory between the RISC-V instruction-fetch port and the load/store data port.
- Arbitrates between the two ports with round-robin on ties.
- Sequences the memory handshake and returns responses to the requesting port.
- Provides a stall to the core control while either port is waiting.
- Sits between the core's fetch/load-store logic and the memory model; includes a bus-timeout watchdog.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte enables are DATA_WIDTH/8 bits.
- TIMEOUT_CYCLES, 16, max cycles waiting for memReady before error; 0 disables the watchdog.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- instrReq  input  1  fetch request; held until instrAck.
- instrAddress  input  ADDR_WIDTH  fetch address.
- instrAck  output  1  one-cycle response pulse to the fetch port.
- instrData  output  DATA_WIDTH  fetched word; valid with instrAck.
- dataReq  input  1  load/store request; held until dataAck.
- dataWrite  input  1  1 = store, 0 = load.
- dataAddress  input  ADDR_WIDTH  load/store address.
- dataWriteData  input  DATA_WIDTH  store data.
- dataByteEnable  input  DATA_WIDTH/8  store byte mask.
- dataAck  output  1  one-cycle response pulse to the data port.
- dataReadData  output  DATA_WIDTH  load data; valid with dataAck.
- memRequest  output  1  memory access active.
- memWrite  output  1  memory write strobe.
- memAddress  output  ADDR_WIDTH  memory address.
- memWriteData  output  DATA_WIDTH  memory write data.
- memByteEnable  output  DATA_WIDTH/8  memory byte mask.
- memReadData  input  DATA_WIDTH  memory read data; valid with memReady.
- memReady  input  1  access complete; sampled only while memRequest=1.
- busError  output  1  one-cycle pulse with the ack when a timeout ends the access.
- stall  output  1  combinational: (instrReq & ~instrAck) | (dataReq & ~dataAck).

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE and the timeout counter clears.
  - lastGrant = INSTR, so data wins the first tie.
  - All registered outputs clear to 0: mem* outputs, acks, read data outputs, busError.
  - Reset mid-access abandons the access; memRequest is 0 the cycle after the reset edge.
- States: IDLE, BUSY_INSTR, BUSY_DATA, DONE.
- IDLE:
  - Only dataReq → go to BUSY_DATA.
  - Only instrReq → go to BUSY_INSTR.
  - Both → grant the port opposite lastGrant.
  - On grant: register address, write, write data and byte enables into the mem* outputs, set memRequest=1, update lastGrant.
  - Instruction grants drive memWrite=0 and memByteEnable all ones.
- BUSY_*:
  - mem* outputs are held stable; request inputs are ignored.
  - The counter increments each cycle.
  - memReady=1 → capture memReadData into the granted port's data output and go to DONE with that ack=1. For stores the read data output is 0.
  - TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without memReady → go to DONE with ack=1, busError=1, read data 0.
  - On leaving BUSY, memRequest and memWrite clear.
- DONE: lasts exactly one cycle.
  - The ack (and busError if set) is high.
  - No grant is made, even if requests are present.
  - Next state is IDLE; the ack, busError and counter clear.
- Handshake:
  - A requester holds req and its operands stable until its ack.
  - It may deassert or present a new request in the ack cycle; that request is seen in the following IDLE cycle.
- Latency:
  - Request visible in IDLE at cycle N → memRequest=1 at N+1.
  - memReady at cycle M ≥ N+1 → ack at M+1 → earliest next grant decision at M+2.
  - Zero-wait memory therefore gives 3 cycles per access, with one access in flight at a time.
- Requests arriving during BUSY/DONE wait; stall stays high for them.
- memReady while memRequest=0 is ignored.
- A request dropped before its ack (protocol violation) does not cancel an in-flight access; the ack still pulses.

Test Plan:
- Fetch only: instrReq=1, addr 0x100, memory returns 0x00500093 with memReady one cycle after memRequest → instrAck pulses for exactly 1 cycle with instrData=0x00500093, memWrite=0, stall low after the ack.
- Store: dataReq=1, dataWrite=1, addr 0x200, data 0xDEADBEEF, byteEnable 4'b0011 → memWrite=1, memAddress=0x200, memByteEnable=0011 while busy; dataAck pulses and dataReadData=0.
- Tie round-robin after reset: both requests held continuously → grant order DATA, INSTR, DATA, INSTR, with one DONE gap cycle between accesses.
- Wait states: memReady delayed 5 cycles → mem* outputs stable throughout, stall high, ack on the cycle after memReady.
- Timeout: TIMEOUT_CYCLES=4, memReady never asserts → ack plus busError pulse 4 cycles after memRequest rises; dataReadData=0; state returns to IDLE.
- Reset mid-access: rst_n=0 during BUSY_DATA → next cycle memRequest=0, no ack; the first tie after reset is granted to data.
